// File: rtl/rx_pd_pkg.sv
// rtl/rx_pd_pkg.sv - state encoding and config helpers shared by the rx_pd packet detector
package rx_pd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_HUNT   = 2'd2,
        ST_LOCKED = 2'd3
    } pd_state_e;

    // Period 0 means "compare with the previous symbol"; oversize periods fall back to the deepest tap.
    function automatic int unsigned clamp_period(input int unsigned period, input int unsigned max_period);
        if (period == 0) return 1;
        if (period > max_period) return max_period;
        return period;
    endfunction

endpackage

// File: rtl/rx_pd_hist.sv
// rtl/rx_pd_hist.sv - symbol delay line with a tap P symbols back and a tap one symbol back
module rx_pd_hist #(
    parameter int SYM_W      = 2,
    parameter int MAX_PERIOD = 8,
    parameter int PER_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_shift,
    input  logic [SYM_W-1:0] i_sym,
    input  logic [PER_W-1:0] i_period,
    output logic [SYM_W-1:0] o_tap_p,
    output logic [SYM_W-1:0] o_tap_0
);

    logic [SYM_W-1:0] r_hist [MAX_PERIOD];

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            for (int i = 0; i < MAX_PERIOD; i++) r_hist[i] <= '0;
        end else if (i_shift) begin
            r_hist[0] <= i_sym;
            for (int i = 1; i < MAX_PERIOD; i++) r_hist[i] <= r_hist[i-1];
        end
    end

    // r_hist[k] holds the symbol received k+1 valids ago.
    always_comb begin
        o_tap_p = r_hist[0];
        for (int i = 0; i < MAX_PERIOD; i++) begin
            if (i_period == PER_W'(i + 1)) o_tap_p = r_hist[i];
        end
    end

    assign o_tap_0 = r_hist[0];

endmodule

// File: rtl/rx_pd_multi.sv
// rtl/rx_pd_multi.sv - periodic-preamble packet detector with error tolerance and auto-release
module rx_pd_multi
    import rx_pd_pkg::*;
#(
    parameter int SYM_W      = 2,
    parameter int MAX_PERIOD = 8,
    parameter int PER_W      = 4,
    parameter int CNT_W      = 8,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym,
    input  logic             SD_flag,
    input  logic             disassert_PD,
    input  logic [PER_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_window,
    input  logic [CNT_W-1:0] cfg_max_err,
    input  logic [LEN_W-1:0] cfg_pkt_len,
    output logic             PD_flag,
    output logic             PD_pulse,
    output logic [CNT_W-1:0] lock_err
);

    pd_state_e        r_state, w_state_n;
    logic [PER_W-1:0] r_period, r_fill, w_fill_n;
    logic [CNT_W-1:0] r_window, r_max_err;
    logic [LEN_W-1:0] r_pkt_len, r_pkt, w_pkt_n, w_pkt_inc;
    logic [CNT_W-1:0] r_hit, w_hit_n, w_hit_inc;
    logic [CNT_W-1:0] r_err, w_err_n, w_err_inc;
    logic [CNT_W-1:0] r_lock_err, w_lock_err_n;
    logic             r_trans, w_trans_n;
    logic             r_pd, w_pd_n, r_pulse, w_pulse_n;
    logic             w_latch_cfg, w_shift, w_release, w_hist_clr;
    logic             w_match, w_changed;
    logic [SYM_W-1:0] w_tap_p, w_tap_0;

    rx_pd_hist #(
        .SYM_W      (SYM_W),
        .MAX_PERIOD (MAX_PERIOD),
        .PER_W      (PER_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_hist_clr),
        .i_shift  (w_shift),
        .i_sym    (sym),
        .i_period (r_period),
        .o_tap_p  (w_tap_p),
        .o_tap_0  (w_tap_0)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_n;
    end

    always_comb begin
        w_state_n    = r_state;
        w_fill_n     = r_fill;
        w_hit_n      = r_hit;
        w_err_n      = r_err;
        w_trans_n    = r_trans;
        w_pkt_n      = r_pkt;
        w_pd_n       = r_pd;
        w_pulse_n    = 1'b0;
        w_lock_err_n = r_lock_err;
        w_latch_cfg  = 1'b0;
        w_shift      = 1'b0;
        w_release    = 1'b0;
        w_hist_clr   = 1'b0;
        w_hit_inc    = (r_hit >= r_window) ? r_hit : r_hit + CNT_W'(1);
        w_err_inc    = (r_err == '1) ? r_err : r_err + CNT_W'(1);
        w_pkt_inc    = (r_pkt == '1) ? r_pkt : r_pkt + LEN_W'(1);
        w_match      = (sym == w_tap_p);
        w_changed    = (sym != w_tap_0);

        if (!SD_flag) begin
            w_state_n    = ST_IDLE;
            w_fill_n     = '0;
            w_hit_n      = '0;
            w_err_n      = '0;
            w_trans_n    = 1'b0;
            w_pkt_n      = '0;
            w_pd_n       = 1'b0;
            w_lock_err_n = '0;
            w_hist_clr   = 1'b1;
        end else if (r_state == ST_IDLE) begin
            w_state_n   = ST_FILL;
            w_latch_cfg = 1'b1;
        end else if (disassert_PD) begin
            w_release = 1'b1;
        end else if (sym_valid) begin
            w_shift = 1'b1;
            case (r_state)
                ST_FILL: begin
                    if (r_fill + PER_W'(1) >= r_period) begin
                        w_state_n = ST_HUNT;
                        w_fill_n  = '0;
                    end else begin
                        w_fill_n = r_fill + PER_W'(1);
                    end
                end
                ST_HUNT: begin
                    if (w_match) begin
                        w_hit_n   = w_hit_inc;
                        w_trans_n = r_trans | w_changed;
                    end else if (w_err_inc > r_max_err) begin
                        w_hit_n   = '0;
                        w_err_n   = '0;
                        w_trans_n = 1'b0;
                    end else begin
                        w_err_n   = w_err_inc;
                        w_trans_n = r_trans | w_changed;
                    end
                    // trans rejects DC input that would otherwise match at every period.
                    if (w_hit_n >= r_window && w_trans_n) begin
                        w_state_n    = ST_LOCKED;
                        w_pd_n       = 1'b1;
                        w_pulse_n    = 1'b1;
                        w_lock_err_n = w_err_n;
                        w_pkt_n      = '0;
                    end
                end
                ST_LOCKED: begin
                    w_pkt_n = w_pkt_inc;
                    if (r_pkt_len != '0 && w_pkt_inc == r_pkt_len) w_release = 1'b1;
                end
                default: ;
            endcase
        end

        if (w_release) begin
            w_state_n  = ST_FILL;
            w_fill_n   = '0;
            w_hit_n    = '0;
            w_err_n    = '0;
            w_trans_n  = 1'b0;
            w_pkt_n    = '0;
            w_pd_n     = 1'b0;
            w_shift    = 1'b0;
            w_hist_clr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_period   <= PER_W'(1);
            r_window   <= CNT_W'(1);
            r_max_err  <= '0;
            r_pkt_len  <= '0;
            r_fill     <= '0;
            r_hit      <= '0;
            r_err      <= '0;
            r_trans    <= 1'b0;
            r_pkt      <= '0;
            r_pd       <= 1'b0;
            r_pulse    <= 1'b0;
            r_lock_err <= '0;
        end else begin
            if (w_latch_cfg) begin
                r_period  <= PER_W'(clamp_period(32'(cfg_period), MAX_PERIOD));
                r_window  <= (cfg_window == '0) ? CNT_W'(1) : cfg_window;
                r_max_err <= cfg_max_err;
                r_pkt_len <= cfg_pkt_len;
            end
            r_fill     <= w_fill_n;
            r_hit      <= w_hit_n;
            r_err      <= w_err_n;
            r_trans    <= w_trans_n;
            r_pkt      <= w_pkt_n;
            r_pd       <= w_pd_n;
            r_pulse    <= w_pulse_n;
            r_lock_err <= w_lock_err_n;
        end
    end

    assign PD_flag  = r_pd;
    assign PD_pulse = r_pulse;
    assign lock_err = r_lock_err;

endmodule

// File: doc/rx_pd_multi.md
# rx_pd_multi

Parametrised packet detector for the PSK receive chain, placed after the symbol slicer and gated by signal detection (SD). It recognises any periodic preamble of period 1..MAX_PERIOD on multi-bit symbols (BPSK/QPSK), tolerates a programmable number of symbol errors, and rejects constant (DC) input. After lock it releases on command, on loss of SD, or automatically after a programmed packet length.

## Interface
Parameters:
- SYM_W, 2, symbol width in bits (1 = BPSK, 2 = QPSK)
- MAX_PERIOD, 8, maximum preamble period in symbols (≥2)
- PER_W, 4, width of cfg_period (must hold MAX_PERIOD)
- CNT_W, 8, width of the window and error counters
- LEN_W, 16, width of the packet-length counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sym_valid  in  1  strobe marking sym as a new symbol
- sym  in  SYM_W  sliced symbol
- SD_flag  in  1  signal-detect prerequisite
- disassert_PD  in  1  release request from the packet parser
- cfg_period  in  PER_W  preamble period; 0 is treated as 1, values above MAX_PERIOD are clamped to MAX_PERIOD
- cfg_window  in  CNT_W  matches required for lock; 0 is treated as 1
- cfg_max_err  in  CNT_W  mismatches tolerated per run
- cfg_pkt_len  in  LEN_W  symbols after lock before auto-release; 0 disables auto-release
- PD_flag  out  1  packet detected (level)
- PD_pulse  out  1  single-cycle strobe when PD_flag rises
- lock_err  out  CNT_W  error count of the run that achieved lock

## Operation
- States: IDLE, FILL, HUNT, LOCKED.
- IDLE: entered on rst or whenever SD_flag=0. History, counters and outputs are cleared. When SD_flag=1, the block latches cfg_* into shadow registers and moves to FILL. Configuration is used only from the shadows until the next IDLE.
- History: a shift register of MAX_PERIOD symbols, shifted on every sym_valid in FILL, HUNT and LOCKED.
- FILL: the first P = cfg_period valid symbols are shifted in without comparison. Then the block moves to HUNT.
- HUNT: on each valid symbol, match = (sym == hist[P-1]), i.e. the symbol received P symbols earlier.
  - Match: hit_cnt increments, saturating at cfg_window.
  - Mismatch: err_cnt increments. If the new err_cnt would exceed cfg_max_err, hit_cnt, err_cnt and trans are all cleared.
  - trans is set when sym != hist[0]. It is cleared together with hit_cnt.
  - Lock condition: hit_cnt ≥ cfg_window AND trans=1. This moves the block to LOCKED, sets PD_flag, pulses PD_pulse and latches err_cnt into lock_err.
- LOCKED: pkt_cnt increments on each valid symbol. Release returns the block to FILL with the history invalidated and all counters cleared. Release occurs when:
  - disassert_PD=1, or
  - cfg_pkt_len≠0 and pkt_cnt reaches cfg_pkt_len.
- Priority, highest first: rst > ~SD_flag > disassert_PD > length release > symbol processing.
- All counters saturate; none wraps.

## Timing
- Reset values: PD_flag=0, PD_pulse=0, lock_err=0, state IDLE.
- Counters update on the clock edge that samples sym_valid=1.
- PD_flag rises one cycle after the edge where the lock condition first becomes true. PD_pulse is high for exactly that cycle.
- Release takes effect on the edge sampling the cause, so PD_flag=0 on the following cycle.
- SD_flag low for one cycle fully clears the block, including mid-FILL and mid-LOCKED.
- disassert_PD in FILL or HUNT clears the counters and restarts FILL.
- sym_valid=0 cycles change no state. Back-to-back valids every cycle are supported.

## Structure
- Shared package rx_pd_pkg holds the state encoding (IDLE/FILL/HUNT/LOCKED) and the clamp helper function for cfg_period.
- One sub-module, rx_pd_hist: the parametrised symbol delay line with a selectable tap at P-1 and tap 0.

## Test plan
- SYM_W=1, P=2, window=8, max_err=0, input 0101… → PD_flag high 1 cycle after the 8th compared match (10th symbol overall). PD_pulse is high one cycle. lock_err=0.
- Constant 000… with P=1, window=4 → PD_flag never asserts (trans stays 0).
- SYM_W=2, P=4, preamble 0,1,3,2 repeated, one corrupted symbol, max_err=1, window=12 → lock with lock_err=1. Same stimulus with max_err=0 → lock is delayed until 12 clean matches after the error.
- Locked with pkt_len=20 → PD_flag drops 1 cycle after the 20th post-lock valid symbol, and the block re-hunts.
- disassert_PD and SD_flag=0 in the same cycle while LOCKED → state IDLE (not FILL) and PD_flag=0 next cycle. rst during HUNT → all outputs 0.
- sym_valid toggling 1-in-3 with the 0101… stimulus → lock after the same number of valid symbols as the first case.
